rv32m_divider: RTL and testbench

//   Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.

---
 rtl/rv32m_divider.sv | 147 ++++++++++++++
 tb/tb_rv32m_divider.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rv32m_divider.sv
// rv32m_divider: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// A normal operation takes XLEN CALC cycles and then one FIN cycle. Divide-by-zero
// and signed overflow skip CALC and go straight to FIN.
// Ports:
//   clk, rst      core clock (rising edge), synchronous active-high reset
//   flush         cancels any operation; IDLE next cycle, no done pulse
//   start         request, sampled only in IDLE or FIN
//   div_func      00=DIV 01=DIVU 10=REM 11=REMU, sampled with start
//   op1, op2      dividend / divisor, sampled with start
//   busy          high while iterating (CALC)
//   done          one-cycle pulse when result is updated
//   result        quotient or remainder; changes only on entry to FIN
module rv32m_divider #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [1:0]      div_func,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            is_rem;
  logic            neg_q;
  logic            neg_r;
  logic [XLEN-1:0] quo;   // dividend bits shift out MSB-first, quotient bits shift in
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvsr;

  // Launch decode: magnitudes, signs and the two bypass cases
  logic            signed_op;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            ovf;
  logic [XLEN-1:0] special_res;

  always_comb begin
    signed_op   = ~div_func[0];
    a_neg       = signed_op & op1[XLEN-1];
    b_neg       = signed_op & op2[XLEN-1];
    a_mag       = a_neg ? (~op1 + XLEN'(1)) : op1;
    b_mag       = b_neg ? (~op2 + XLEN'(1)) : op2;
    div_zero    = (op2 == '0);
    ovf         = signed_op && (op1 == MIN_INT) && (op2 == '1);
    special_res = '0;
    if (div_zero) special_res = div_func[1] ? op1 : '1;
    else          special_res = div_func[1] ? '0 : MIN_INT;
  end

  // One restoring step; shifted is XLEN+1 bits so the subtraction sign is its MSB
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            qbit;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;
  logic [XLEN-1:0] final_res;

  always_comb begin
    shifted   = {rem, quo[XLEN-1]};
    diff      = shifted - {1'b0, dvsr};
    qbit      = ~diff[XLEN];
    rem_next  = qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_next  = {quo[XLEN-2:0], qbit};
    // Two's-complement negation of zero is zero, so zero results stay unsigned
    if (is_rem) final_res = neg_r ? (~rem_next + XLEN'(1)) : rem_next;
    else        final_res = neg_q ? (~quo_next + XLEN'(1)) : quo_next;
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      is_rem <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      quo    <= '0;
      rem    <= '0;
      dvsr   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            is_rem <= div_func[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            if (div_zero || ovf) begin
              result <= special_res;
              done   <= 1'b1;
              state  <= FIN;
            end else begin
              quo   <= a_mag;
              rem   <= '0;
              dvsr  <= b_mag;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          quo <= quo_next;
          rem <= rem_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(XLEN-1)) begin
            result <= final_res;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= FIN;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32m_divider.sv
// tb_rv32m_divider: directed vectors with hand-computed results; expected results
// and completion cycles are queued at issue and checked by a separate monitor.
module tb_rv32m_divider;

  localparam logic [1:0] F_DIV  = 2'b00;
  localparam logic [1:0] F_DIVU = 2'b01;
  localparam logic [1:0] F_REM  = 2'b10;
  localparam logic [1:0] F_REMU = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  div_func = 2'b00;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  rv32m_divider #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .div_func(div_func),
    .op1(op1), .op2(op2), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          at;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] prev_res = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int lat_of(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Monitor: every cycle with done=1 is one completion
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("done_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  // Called at a negedge; drives start for one cycle and returns at the next negedge
  task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input bit push);
    exp_t x;
    start    = 1'b1;
    div_func = f;
    op1      = a;
    op2      = b;
    if (push) begin
      x.res = e;
      x.at  = cyc + lat_of(f, a, b);
      sb.push_back(x);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full operation from IDLE; checks busy profile and that result holds until done
  task automatic run(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] e);
    int t0;
    int lat;
    int n;
    bit bad;
    t0  = cyc;
    lat = lat_of(f, a, b);
    bad = 1'b0;
    issue(f, a, b, e, 1'b1);
    n = cyc - t0;
    while (n <= lat) begin
      if (busy !== (n < lat)) bad = 1'b1;
      if (n < lat && result !== prev_res) bad = 1'b1;
      if (n == lat) break;
      @(negedge clk);
      n = cyc - t0;
    end
    chk("busy_and_hold", 32'(bad), 32'h0);
    prev_res = e;
    @(negedge clk);
  endtask

  initial begin
    int t0;
    int t1;
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int t1;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_result", result, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    run(F_DIVU, 32'd100, 32'd7, 32'd14);
    run(F_REMU, 32'd100, 32'd7, 32'd2);
    run(F_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run(F_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run(F_REM,  32'd7, 32'hFFFF_FFFE, 32'd1);
    run(F_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run(F_REM,  32'd5, 32'd0, 32'd5);
    run(F_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF);
    run(F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run(F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    run(F_DIVU, 32'd7, 32'd7, 32'd1);
    run(F_REMU, 32'd7, 32'd7, 32'd0);
    run(F_DIVU, 32'd3, 32'd10, 32'd0);
    run(F_REMU, 32'd3, 32'd10, 32'd3);
    run(F_DIV,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
    run(F_REM,  32'hFFFF_FFFC, 32'd2, 32'h0);
    run(F_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
    run(F_DIV,  32'h8000_0000, 32'd1, 32'h8000_0000);
    run(F_DIV,  32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd2);
    run(F_REM,  32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE);
    run(F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

    // Back-to-back: second start held in FIN, stray start during CALC ignored
    t0 = cyc;
    issue(F_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
    while (cyc != t0 + 33) @(negedge clk);
    prev_res = 32'd14;
    t1 = cyc;
    issue(F_DIVU, 32'd9, 32'd3, 32'd3, 1'b1);
    while (cyc != t1 + 5) @(negedge clk);
    start = 1'b1; div_func = F_DIVU; op1 = 32'd5; op2 = 32'd0;
    @(negedge clk);
    start = 1'b0;
    chk("calc_start_ignored_busy", 32'(busy), 32'h1);
    chk("calc_result_hold", result, 32'd14);
    while (cyc != t1 + 34) @(negedge clk);
    chk("b2b_result_hold", result, 32'd3);
    prev_res = 32'd3;

    // Back-to-back special ops: done on two consecutive cycles
    issue(F_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
    issue(F_REM,  32'd5, 32'd0, 32'd5, 1'b1);
    @(negedge clk);
    chk("special_b2b_idle_done", 32'(done), 32'h0);
    prev_res = 32'd5;

    // Flush at cycle 10, new start at cycle 12
    t0 = cyc;
    issue(F_DIVU, 32'd100, 32'd7, 32'd0, 1'b0);
    while (cyc != t0 + 10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'h0);
    chk("flush_done", 32'(done), 32'h0);
    chk("flush_result_hold", result, prev_res);
    @(negedge clk);
    run(F_DIVU, 32'd50, 32'd5, 32'd10);

    // Reset at cycle 5 of an op, with a start in the same cycle
    t0 = cyc;
    issue(F_DIVU, 32'd100, 32'd7, 32'd0, 1'b0);
    while (cyc != t0 + 5) @(negedge clk);
    rst = 1'b1; start = 1'b1; div_func = F_DIVU; op1 = 32'd5; op2 = 32'd0;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    chk("midrst_result", result, 32'h0);
    prev_res = 32'h0;
    repeat (40) @(negedge clk);

    run(F_REMU, 32'd100, 32'd7, 32'd2);
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
